// File: rtl/game_board_wb_responder.sv
// Wishbone slave holding the game board field memory, one byte per field, with a
// self-clearing sequencer after reset or clear_req. Define WB_ERR_EN to flag bad addresses on wb_err_o.
`timescale 1ns/1ps

// state   | meaning
// S_IDLE  | waiting for a strobe or a clear request
// S_ACK   | ack (or err) pulse for the access sampled on the previous edge
// S_CLEAR | zeroing the board, one field per cycle
module game_board_wb_responder #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int ADR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_req,
  output logic             busy,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [7:0]       wb_dat_i,
  output logic [7:0]       wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o
);

  localparam int DEPTH = ROWS * COLS;

  generate
    if ((2 ** ADR_W) < DEPTH) begin : g_adr_w_check
      $error("game_board_wb_responder: ADR_W too small for ROWS*COLS fields");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [ADR_W-1:0] clr_ctr;
  logic [7:0]       dat_q;
  logic [7:0]       mem [DEPTH];
  logic             req;
  logic             adr_ok;
  logic             start;
  logic             last_clr;

  assign req      = wb_cyc_i & wb_stb_i;
  assign adr_ok   = (32'(wb_adr_i) < DEPTH);
  // clear_req wins over a same-cycle strobe; the strobe is picked up after the clear
  assign start    = (state == S_IDLE) & ~clear_req & req;
  assign last_clr = (state == S_CLEAR) & (clr_ctr == ADR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_nx = S_CLEAR;
        end else if (req) begin
          state_nx = S_ACK;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      S_CLEAR: begin
        if (last_clr) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ctr <= '0;
      dat_q   <= 8'h00;
    end else begin
      if (last_clr) begin
        clr_ctr <= '0;
      end else if (state == S_CLEAR) begin
        clr_ctr <= clr_ctr + ADR_W'(1);
      end
      if (start) begin
        dat_q <= (!wb_we_i && adr_ok) ? mem[wb_adr_i] : 8'h00;
      end
    end
  end

  // Field memory has no reset; the CLEAR sequence is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_ctr] <= 8'h00;
    end else if (start && wb_we_i && adr_ok) begin
      mem[wb_adr_i] <= wb_dat_i & 8'h7F;
    end
  end

`ifdef WB_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= ~adr_ok;
    end
  end

  always_comb begin
    busy     = (state == S_CLEAR);
    wb_ack_o = (state == S_ACK) & ~err_q;
    wb_err_o = (state == S_ACK) & err_q;
    wb_dat_o = dat_q;
  end
`else
  always_comb begin
    busy     = (state == S_CLEAR);
    wb_ack_o = (state == S_ACK);
    wb_err_o = 1'b0;
    wb_dat_o = dat_q;
  end
`endif

endmodule
